// File: rtl/cpu_pkg.sv
// Shared types and instruction-format constants for the 8-bit CPU.
// Used by the controller, its decoder, the ALU and the top level.
package cpu_pkg;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LDI  = 4'h6,
    OP_MOV  = 4'h7,
    OP_JMP  = 4'h8,
    OP_BEQZ = 4'h9,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_PASSA = 3'd5,
    ALU_PASSB = 3'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    HALT   = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: instruction word -> register addresses,
// ALU controls and control-flow flags.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [3:0]  ra1,
  output logic [3:0]  ra2,
  output logic [3:0]  wa,
  output alu_op_e     alu_op,
  output logic        imm_sel,
  output logic [7:0]  imm,
  output logic        writes_rd,
  output logic        is_jmp,
  output logic        is_beqz,
  output logic        is_halt
);

  opcode_e op_s;

  // Field extraction and per-opcode control decode.
  always_comb begin
    op_s      = opcode_e'(ir[OP_MSB:OP_LSB]);
    ra1       = ir[RS1_MSB:RS1_LSB];
    ra2       = ir[RS2_MSB:RS2_LSB];
    wa        = ir[RD_MSB:RD_LSB];
    imm       = ir[IMM_MSB:IMM_LSB];
    alu_op    = ALU_ADD;
    imm_sel   = 1'b0;
    writes_rd = 1'b0;
    is_jmp    = 1'b0;
    is_beqz   = 1'b0;
    is_halt   = 1'b0;
    case (op_s)
      OP_ADD:  begin alu_op = ALU_ADD;   writes_rd = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB;   writes_rd = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND;   writes_rd = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;    writes_rd = 1'b1; end
      OP_XOR:  begin alu_op = ALU_XOR;   writes_rd = 1'b1; end
      OP_LDI:  begin alu_op = ALU_PASSB; imm_sel = 1'b1; writes_rd = 1'b1; end
      OP_MOV:  begin alu_op = ALU_PASSA; writes_rd = 1'b1; end
      OP_JMP:  is_jmp = 1'b1;
      // The branch tests the register named in the rd field.
      OP_BEQZ: begin is_beqz = 1'b1; ra1 = ir[RD_MSB:RD_LSB]; end
      OP_HALT: is_halt = 1'b1;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute controller: fetches over a req/valid
// handshake, drives reg_file/ALU controls and sequences the PC.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W     = 8,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic                imem_valid,
  input  logic [15:0]         imem_rdata,
  output logic [3:0]          RA1,
  output logic [3:0]          RA2,
  output logic [3:0]          WA,
  output logic                write_enable,
  input  logic [7:0]          RD1,
  output logic [2:0]          alu_op,
  output logic                imm_sel,
  output logic [7:0]          imm,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  ctrl_state_e         state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;
  logic                fetch_accept_s;

  logic                imem_req_q, write_enable_q, imm_sel_q, halted_q;
  logic [PC_W-1:0]     imem_addr_q;
  logic [3:0]          ra1_q, ra2_q, wa_q;
  logic [2:0]          alu_op_q;
  logic [7:0]          imm_q;

  logic [3:0]          dec_ra1_s, dec_ra2_s, dec_wa_s;
  alu_op_e             dec_alu_op_s;
  logic                dec_imm_sel_s, dec_writes_rd_s;
  logic                dec_is_jmp_s, dec_is_beqz_s, dec_is_halt_s;
  logic [7:0]          dec_imm_s;

  // Capture the instruction word when a fetch handshake completes.
  always_comb begin
    fetch_accept_s = 1'b0;
    ir_d           = ir_q;
    if ((state_q == FETCH) && imem_req_q && imem_valid) begin
      fetch_accept_s = 1'b1;
      ir_d           = imem_rdata;
    end else begin
      fetch_accept_s = 1'b0;
      ir_d           = ir_q;
    end
  end

  // Decoding ir_d lets the registered controls be valid on entry to DECODE.
  cpu_decode u_decode (
    .ir        (ir_d),
    .ra1       (dec_ra1_s),
    .ra2       (dec_ra2_s),
    .wa        (dec_wa_s),
    .alu_op    (dec_alu_op_s),
    .imm_sel   (dec_imm_sel_s),
    .imm       (dec_imm_s),
    .writes_rd (dec_writes_rd_s),
    .is_jmp    (dec_is_jmp_s),
    .is_beqz   (dec_is_beqz_s),
    .is_halt   (dec_is_halt_s)
  );

  // Next-state, PC and retire-counter sequencing.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    case (state_q)
      FETCH: begin
        if (fetch_accept_s) begin
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (dec_is_halt_s) begin
          state_d = HALT;
        end else begin
          state_d   = FETCH;
          retired_d = retired_q + RETIRE_W'(1);
          if (dec_is_jmp_s || (dec_is_beqz_s && (RD1 == 8'd0))) begin
            pc_d = PC_W'(dec_imm_s);
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // State, PC, IR, counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FETCH;
      pc_q           <= '0;
      ir_q           <= 16'h0000;
      retired_q      <= '0;
      imem_req_q     <= 1'b0;
      imem_addr_q    <= '0;
      ra1_q          <= 4'd0;
      ra2_q          <= 4'd0;
      wa_q           <= 4'd0;
      write_enable_q <= 1'b0;
      alu_op_q       <= 3'd0;
      imm_sel_q      <= 1'b0;
      imm_q          <= 8'd0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      retired_q      <= retired_d;
      imem_req_q     <= (state_d == FETCH);
      imem_addr_q    <= pc_d;
      ra1_q          <= dec_ra1_s;
      ra2_q          <= dec_ra2_s;
      wa_q           <= dec_wa_s;
      write_enable_q <= (state_d == EXEC) && dec_writes_rd_s;
      alu_op_q       <= dec_alu_op_s;
      imm_sel_q      <= dec_imm_sel_s;
      imm_q          <= dec_imm_s;
      halted_q       <= (state_d == HALT);
    end
  end

  assign imem_req     = imem_req_q;
  assign imem_addr    = imem_addr_q;
  assign RA1          = ra1_q;
  assign RA2          = ra2_q;
  assign WA           = wa_q;
  assign write_enable = write_enable_q;
  assign alu_op       = alu_op_q;
  assign imm_sel      = imm_sel_q;
  assign imm          = imm_q;
  assign halted       = halted_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed-vector bench for cpu_ctrl with hand-computed expectations.
module tb_cpu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic [3:0]  RA1, RA2, WA;
  logic        write_enable;
  logic [7:0]  RD1;
  logic [2:0]  alu_op;
  logic        imm_sel;
  logic [7:0]  imm;
  logic        halted;
  logic [15:0] retired;

  int n_checks;
  int n_fails;

  cpu_ctrl #(.PC_W(8), .RETIRE_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .write_enable (write_enable),
    .RD1          (RD1),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .imm          (imm),
    .halted       (halted),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold off valid for 'delay' cycles checking req/addr, then deliver instr.
  // Returns just after the edge that moves the controller into DECODE.
  task automatic issue(input logic [15:0] instr, input int delay, input logic [7:0] addr);
    for (int i = 0; i < delay; i++) begin
      check_eq("fetch_req_wait", 32'(imem_req), 32'd1);
      check_eq("fetch_addr_wait", 32'(imem_addr), 32'(addr));
      tick();
    end
    check_eq("fetch_req", 32'(imem_req), 32'd1);
    check_eq("fetch_addr", 32'(imem_addr), 32'(addr));
    imem_valid = 1'b1;
    imem_rdata = instr;
    tick();
    imem_valid = 1'b0;
    imem_rdata = 16'h0000;
  endtask

  // Runs DECODE and EXEC of a non-writing instruction, ending back in FETCH.
  task automatic run_flow(input string tag, input logic [7:0] next_addr, input logic [15:0] exp_ret);
    check_eq({tag, "_dec_we"}, 32'(write_enable), 32'd0);
    tick();
    check_eq({tag, "_exec_we"}, 32'(write_enable), 32'd0);
    tick();
    check_eq({tag, "_next_addr"}, 32'(imem_addr), 32'(next_addr));
    check_eq({tag, "_retired"}, 32'(retired), 32'(exp_ret));
  endtask

  initial begin
    logic saw_we;
    n_checks   = 0;
    n_fails    = 0;
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_rdata = 16'h0000;
    RD1        = 8'h00;

    #3;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_we", 32'(write_enable), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_retired", 32'(retired), 32'd0);
    check_eq("rst_alu_op", 32'(alu_op), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: LDI r10,5 delivered on the first req cycle
    issue(16'h6A05, 0, 8'h00);
    check_eq("ldi_dec_req", 32'(imem_req), 32'd0);
    check_eq("ldi_dec_we", 32'(write_enable), 32'd0);
    tick();
    check_eq("ldi_we", 32'(write_enable), 32'd1);
    check_eq("ldi_wa", 32'(WA), 32'd10);
    check_eq("ldi_imm_sel", 32'(imm_sel), 32'd1);
    check_eq("ldi_imm", 32'(imm), 32'h05);
    check_eq("ldi_alu_op", 32'(alu_op), 32'd6);
    tick();
    check_eq("ldi_we_off", 32'(write_enable), 32'd0);
    check_eq("ldi_next_addr", 32'(imem_addr), 32'h01);
    check_eq("ldi_retired", 32'(retired), 32'd1);

    // 2: ADD r3,r1,r2 with valid delayed 4 cycles
    issue(16'h1312, 4, 8'h01);
    check_eq("add_ra1", 32'(RA1), 32'd1);
    check_eq("add_ra2", 32'(RA2), 32'd2);
    check_eq("add_dec_we", 32'(write_enable), 32'd0);
    tick();
    check_eq("add_we", 32'(write_enable), 32'd1);
    check_eq("add_wa", 32'(WA), 32'd3);
    check_eq("add_alu_op", 32'(alu_op), 32'd0);
    check_eq("add_imm_sel", 32'(imm_sel), 32'd0);
    check_eq("add_ra1_exec", 32'(RA1), 32'd1);
    tick();
    check_eq("add_we_off", 32'(write_enable), 32'd0);
    check_eq("add_next_addr", 32'(imem_addr), 32'h02);
    check_eq("add_retired", 32'(retired), 32'd2);

    // 3: BEQZ r4,0x20 taken, then not taken
    RD1 = 8'h00;
    issue(16'h9420, 0, 8'h02);
    check_eq("beqz_ra1", 32'(RA1), 32'd4);
    run_flow("beqz_taken", 8'h20, 16'd3);
    RD1 = 8'h07;
    issue(16'h9420, 0, 8'h20);
    check_eq("beqz2_ra1", 32'(RA1), 32'd4);
    run_flow("beqz_not_taken", 8'h21, 16'd4);
    RD1 = 8'h00;

    // 4: jump to 0xFF, NOP wraps to 0x00, JMP 0x80
    issue(16'h80FF, 0, 8'h21);
    run_flow("jmp_ff", 8'hFF, 16'd5);
    issue(16'h0000, 0, 8'hFF);
    run_flow("nop_wrap", 8'h00, 16'd6);
    issue(16'h8080, 0, 8'h00);
    run_flow("jmp_80", 8'h80, 16'd7);

    // 5: HALT is terminal and not retired
    issue(16'hF000, 0, 8'h80);
    tick();
    tick();
    check_eq("halt_halted", 32'(halted), 32'd1);
    check_eq("halt_req", 32'(imem_req), 32'd0);
    check_eq("halt_retired", 32'(retired), 32'd7);
    saw_we = 1'b0;
    imem_rdata = 16'h6A05;
    for (int i = 0; i < 20; i++) begin
      imem_valid = ~imem_valid;
      tick();
      if (write_enable || imem_req || !halted) saw_we = 1'b1;
    end
    imem_valid = 1'b0;
    check_eq("halt_stuck", 32'(saw_we), 32'd0);
    check_eq("halt_retired_frozen", 32'(retired), 32'd7);
    check_eq("halt_addr_frozen", 32'(imem_addr), 32'h80);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("halt_async_clear", 32'(halted), 32'd0);
    check_eq("halt_async_addr", 32'(imem_addr), 32'd0);
    check_eq("halt_async_retired", 32'(retired), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 6: reset during an outstanding fetch
    issue(16'h0000, 0, 8'h00);
    run_flow("pre_rst_nop", 8'h01, 16'd1);
    check_eq("pre_rst_req", 32'(imem_req), 32'd1);
    #2;
    rst_n      = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 16'h6A05;
    #1;
    check_eq("rst_mid_req", 32'(imem_req), 32'd0);
    check_eq("rst_mid_addr", 32'(imem_addr), 32'd0);
    tick();
    rst_n      = 1'b1;
    imem_valid = 1'b0;
    imem_rdata = 16'h0000;
    tick();
    check_eq("rst_mid_retired", 32'(retired), 32'd0);
    issue(16'h6A05, 0, 8'h00);
    tick();
    check_eq("restart_we", 32'(write_enable), 32'd1);
    check_eq("restart_wa", 32'(WA), 32'd10);
    tick();
    check_eq("restart_addr", 32'(imem_addr), 32'h01);
    check_eq("restart_retired", 32'(retired), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
